// File: rtl/lock_key_sender_if.sv
// Key-group handshake between the keypad front end and lock_key_sender.
// master drives groups in; slave (the sender) returns key_ready.
interface lock_key_sender_if;
    logic       key_valid;
    logic [7:0] key_data;
    logic       key_last;
    logic       key_ready;

    modport master (
        output key_valid,
        output key_data,
        output key_last,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_data,
        input  key_last,
        output key_ready
    );
endinterface

// File: rtl/lock_key_sender.sv
// Keypad-side transmitter: turns BCD key groups into the lock's toggle-per-byte
// number protocol, then issues the timed finish/clear strobes and the mode level.
module lock_key_sender #(
    parameter int unsigned PASSWORD_LENGTH = 3,
    parameter int unsigned GAP_CYCLES      = 4,
    parameter int unsigned FINISH_CYCLES   = 8,
    parameter int unsigned CLEAR_CYCLES    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_mode,
    lock_key_sender_if.slave         key,
    input  logic                     clear_req,
    output logic [3:0]               control_signal,
    output logic [7:0]               input_number,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned CntW   = $clog2(PASSWORD_LENGTH + 1);
    localparam int unsigned TimerW = 16;

    typedef enum logic [2:0] {StIdle, StSetup, StGap, StFinish, StClear} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [7:0]          num_q, num_d;
    logic                toggle_q, toggle_d;
    logic                clear_pend_q, clear_pend_d;
    logic                last_q, last_d;
    logic                finish_q, finish_d;
    logic                clear_q, clear_d;
    logic                mode_q, mode_d;
    logic                done_q, done_d;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        timer_d      = timer_q;
        num_d        = num_q;
        toggle_d     = toggle_q;
        clear_pend_d = clear_pend_q;
        last_d       = last_q;
        finish_d     = finish_q;
        clear_d      = clear_q;
        mode_d       = set_mode;
        done_d       = 1'b0;

        // Requests outside IDLE collapse into one pending clear.
        if (clear_req && state_q != StIdle) begin
            clear_pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (clear_pend_q || clear_req) begin
                    state_d      = StClear;
                    clear_pend_d = 1'b0;
                    clear_d      = 1'b1;
                    timer_d      = TimerW'(CLEAR_CYCLES - 1);
                end else if (key.key_valid) begin
                    num_d   = key.key_data;
                    last_d  = key.key_last || (count_q == CntW'(PASSWORD_LENGTH - 1));
                    count_d = count_q + CntW'(1);
                    state_d = StSetup;
                end
            end
            StSetup: begin
                toggle_d = ~toggle_q;
                timer_d  = TimerW'(GAP_CYCLES - 1);
                state_d  = StGap;
            end
            StGap: begin
                if (timer_q == '0) begin
                    if (last_q) begin
                        state_d  = StFinish;
                        finish_d = 1'b1;
                        timer_d  = TimerW'(FINISH_CYCLES - 1);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StFinish: begin
                if (timer_q == '0) begin
                    finish_d = 1'b0;
                    done_d   = 1'b1;
                    count_d  = '0;
                    state_d  = StIdle;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StClear: begin
                if (timer_q == '0) begin
                    clear_d = 1'b0;
                    count_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            count_q      <= '0;
            timer_q      <= '0;
            num_q        <= 8'h00;
            toggle_q     <= 1'b0;
            clear_pend_q <= 1'b0;
            last_q       <= 1'b0;
            finish_q     <= 1'b0;
            clear_q      <= 1'b0;
            mode_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            num_q        <= num_d;
            toggle_q     <= toggle_d;
            clear_pend_q <= clear_pend_d;
            last_q       <= last_d;
            finish_q     <= finish_d;
            clear_q      <= clear_d;
            mode_q       <= mode_d;
            done_q       <= done_d;
        end
    end

    assign key.key_ready    = !rst && (state_q == StIdle) && !clear_pend_q && !clear_req;
    assign control_signal   = {mode_q, toggle_q, clear_q, finish_q};
    assign input_number     = num_q;
    assign busy             = (state_q != StIdle) || clear_pend_q;
    assign done             = done_q;

endmodule

// File: tb/tb_lock_key_sender.sv
// Directed bench for lock_key_sender: frames, auto-finish, pending clear,
// clear/key collision, mode latency and mid-frame reset.
module tb_lock_key_sender;

    logic       clk;
    logic       rst;
    logic       set_mode;
    logic       clear_req;
    logic [3:0] control_signal;
    logic [7:0] input_number;
    logic       busy;
    logic       done;

    lock_key_sender_if key_if ();

    lock_key_sender dut (
        .clk            (clk),
        .rst            (rst),
        .set_mode       (set_mode),
        .key            (key_if),
        .clear_req      (clear_req),
        .control_signal (control_signal),
        .input_number   (input_number),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int now     = 0;
    logic exp_tog = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All sampling and driving happens on falling edges; 'now' counts them.
    task automatic step();
        @(negedge clk);
        now++;
    endtask

    task automatic send_key(input logic [7:0] data, input logic last, output int acc);
        int budget;
        key_if.key_valid = 1'b1;
        key_if.key_data  = data;
        key_if.key_last  = last;
        #1;
        budget = 40;
        while (!key_if.key_ready && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("ready_timeout", 32'(key_if.key_ready), 32'd1);
        acc = now;
        step();
        key_if.key_valid = 1'b0;
    endtask

    task automatic send_group(input logic [7:0] data, input logic last, output int acc);
        send_key(data, last, acc);
        check("number_latched", 32'(input_number), 32'(data));
        check("toggle_before_flip", 32'(control_signal[2]), 32'(exp_tog));
        step();
        exp_tog = ~exp_tog;
        check("toggle_after_flip", 32'(control_signal[2]), 32'(exp_tog));
    endtask

    task automatic expect_finish(input int acc);
        int highs;
        int first_high;
        int dones;
        int done_at;
        highs = 0; first_high = -1; dones = 0; done_at = -1;
        while (now < acc + 5) step();
        for (int i = 0; i < 10; i++) begin
            if (control_signal[0]) begin
                highs++;
                if (first_high < 0) first_high = now;
            end
            if (done) begin
                dones++;
                done_at = now;
            end
            step();
        end
        check("finish_len", 32'(highs), 32'd8);
        check("finish_start", 32'(first_high - acc), 32'd6);
        check("done_count", 32'(dones), 32'd1);
        check("done_pos", 32'(done_at - acc), 32'd14);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic expect_no_finish(input int acc);
        int highs;
        int dones;
        highs = 0; dones = 0;
        while (now < acc + 5) step();
        for (int i = 0; i < 10; i++) begin
            if (control_signal[0]) highs++;
            if (done) dones++;
            step();
        end
        check("no_finish_strobe", 32'(highs), 32'd0);
        check("no_done", 32'(dones), 32'd0);
    endtask

    initial begin
        int a0;
        int a1;
        int a2;
        int n;
        int bad;

        rst              = 1'b1;
        set_mode         = 1'b0;
        clear_req        = 1'b0;
        key_if.key_valid = 1'b1;
        key_if.key_data  = 8'h55;
        key_if.key_last  = 1'b0;

        // Reset held three cycles with a key offered.
        repeat (3) step();
        check("rst_ready", 32'(key_if.key_ready), 32'd0);
        check("rst_ctrl", 32'(control_signal), 32'd0);
        check("rst_number", 32'(input_number), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        key_if.key_valid = 1'b0;
        #1;
        check("ready_after_rst", 32'(key_if.key_ready), 32'd1);

        // Frame CC, AA, 11 with explicit last.
        send_group(8'hCC, 1'b0, a0);
        check("busy_in_gap", 32'(busy), 32'd1);
        send_group(8'hAA, 1'b0, a1);
        check("spacing_1", 32'(a1 - a0), 32'd6);
        send_group(8'h11, 1'b1, a2);
        check("spacing_2", 32'(a2 - a1), 32'd6);
        expect_finish(a2);

        // Auto-finish on the third group, fourth starts a new frame.
        send_group(8'h01, 1'b0, a0);
        send_group(8'h02, 1'b0, a1);
        send_group(8'h03, 1'b0, a2);
        expect_finish(a2);
        send_group(8'h04, 1'b0, a0);
        expect_no_finish(a0);

        // Pending clear during the GAP of the second group.
        send_group(8'h21, 1'b0, a0);
        step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("pend_busy", 32'(busy), 32'd1);
        while (now < a0 + 6) step();
        check("pend_clr_low", 32'(control_signal[1]), 32'd0);
        step();
        check("pend_clr_hi1", 32'(control_signal[1]), 32'd1);
        check("pend_no_fin", 32'(control_signal[0]), 32'd0);
        step();
        check("pend_clr_hi2", 32'(control_signal[1]), 32'd1);
        step();
        check("pend_clr_end", 32'(control_signal[1]), 32'd0);
        check("pend_ready", 32'(key_if.key_ready), 32'd1);
        check("pend_keep_num", 32'(input_number), 32'h21);
        check("pend_keep_tog", 32'(control_signal[2]), 32'(exp_tog));
        check("pend_done", 32'(done), 32'd0);
        send_group(8'h12, 1'b0, a0);
        expect_no_finish(a0);
        send_group(8'h13, 1'b0, a0);
        expect_no_finish(a0);
        send_group(8'h14, 1'b0, a0);
        expect_finish(a0);

        // Clear and key in the same IDLE cycle: clear first, key after.
        n = now;
        clear_req        = 1'b1;
        key_if.key_valid = 1'b1;
        key_if.key_data  = 8'hCC;
        key_if.key_last  = 1'b0;
        #1;
        check("coll_ready", 32'(key_if.key_ready), 32'd0);
        step();
        clear_req = 1'b0;
        check("coll_clr1", 32'(control_signal[1]), 32'd1);
        check("coll_wait", 32'(key_if.key_ready), 32'd0);
        step();
        check("coll_clr2", 32'(control_signal[1]), 32'd1);
        step();
        check("coll_clr_end", 32'(control_signal[1]), 32'd0);
        check("coll_ready_back", 32'(key_if.key_ready), 32'd1);
        check("coll_tog_kept", 32'(control_signal[2]), 32'(exp_tog));
        check("coll_num_kept", 32'(input_number), 32'h14);
        step();
        key_if.key_valid = 1'b0;
        check("coll_accept", 32'(input_number), 32'hCC);
        check("coll_elapsed", 32'(now - n), 32'd4);
        step();
        exp_tog = ~exp_tog;
        check("coll_tog_flip", 32'(control_signal[2]), 32'(exp_tog));

        // Mode level, including a change mid-FINISH, then reset during FINISH.
        set_mode = 1'b1;
        #1;
        check("mode_lat0", 32'(control_signal[3]), 32'd0);
        step();
        check("mode_rise", 32'(control_signal[3]), 32'd1);
        send_group(8'hDD, 1'b1, a0);
        while (now < a0 + 8) step();
        set_mode = 1'b0;
        check("mode_mid_fin", 32'(control_signal[3]), 32'd1);
        step();
        check("mode_fall", 32'(control_signal[3]), 32'd0);
        check("fin_active", 32'(control_signal[0]), 32'd1);
        step();
        set_mode = 1'b1;
        rst      = 1'b1;
        step();
        check("midrst_ctrl", 32'(control_signal), 32'd0);
        check("midrst_num", 32'(input_number), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(key_if.key_ready), 32'd0);
        rst = 1'b0;
        exp_tog = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || control_signal[0]) bad++;
            step();
        end
        check("midrst_no_done", 32'(bad), 32'd0);
        check("midrst_mode", 32'(control_signal[3]), 32'd1);

        // Count restarted: three fresh groups produce a finish.
        send_group(8'h31, 1'b0, a0);
        send_group(8'h32, 1'b0, a1);
        send_group(8'h33, 1'b0, a2);
        expect_finish(a2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
